// File: rtl/sync_filter_edge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sync_filter_edge: CH-channel synchronizer, glitch filter, rise/fall pulses |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module sync_filter_edge #(
  parameter int            CH       = 4,
  parameter int            STAGE    = 3,
  parameter logic [CH-1:0] RST_VAL  = {CH{1'b0}},
  parameter int            FILT_LEN = 4
) (
  input  logic          I_CLK,
  input  logic          I_RST,
  input  logic [CH-1:0] I_ASYNC,
  input  logic          I_FILT_EN,
  output logic [CH-1:0] O_SYNC,
  output logic [CH-1:0] O_LEVEL,
  output logic [CH-1:0] O_RISE,
  output logic [CH-1:0] O_FALL,
  output logic          O_CHG
);

  localparam int               CNT_W = $clog2(FILT_LEN + 1);
  localparam logic [CNT_W-1:0] c_THR = CNT_W'(FILT_LEN - 1);

  logic [STAGE-1:0][CH-1:0] r_stage;
  logic [CH-1:0]            r_level;
  logic [CH-1:0]            r_rise;
  logic [CH-1:0]            r_fall;
  logic                     r_chg;
  logic [CH-1:0]            w_next_level;
  logic [CNT_W-1:0]         w_thr;

  // Bypass behaves as a one-cycle filter: a zero threshold accepts on first mismatch.
  assign w_thr = I_FILT_EN ? c_THR : '0;

  always_ff @(posedge I_CLK or posedge I_RST) begin
    if (I_RST) begin
      r_stage <= {STAGE{RST_VAL}};
    end else begin
      r_stage <= {r_stage[STAGE-2:0], I_ASYNC};
    end
  end

  generate
    for (genvar g = 0; g < CH; g++) begin : g_ch
      logic [CNT_W-1:0] r_cnt;
      logic             w_diff;
      logic             w_take;

      assign w_diff          = r_stage[STAGE-1][g] ^ r_level[g];
      assign w_take          = w_diff && (r_cnt >= w_thr);
      assign w_next_level[g] = w_take ? r_stage[STAGE-1][g] : r_level[g];

      always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) begin
          r_cnt <= '0;
        end else if (!w_diff || w_take) begin
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  endgenerate

  always_ff @(posedge I_CLK or posedge I_RST) begin
    if (I_RST) begin
      r_level <= RST_VAL;
      r_rise  <= '0;
      r_fall  <= '0;
      r_chg   <= 1'b0;
    end else begin
      r_level <= w_next_level;
      r_rise  <= w_next_level & ~r_level;
      r_fall  <= ~w_next_level & r_level;
      r_chg   <= |(w_next_level ^ r_level);
    end
  end

  assign O_SYNC  = r_stage[STAGE-1];
  assign O_LEVEL = r_level;
  assign O_RISE  = r_rise;
  assign O_FALL  = r_fall;
  assign O_CHG   = r_chg;

endmodule
`default_nettype wire

// File: doc/sync_filter_edge.md
Name: sync_filter_edge

Overview:
- Multi-channel successor to the single-bus SYNCHRONIZER.
- Brings CH asynchronous single-bit signals (camera VSYNC/HREF/PCLK-derived flags, buttons, status) into the I_CLK domain through a STAGE-deep flop chain.
- Adds a per-channel glitch filter (stability counter) and registered rise/fall pulse outputs.
- Sits at every CAM2VGA clock-domain boundary for control bits. Multi-bit data buses are not handled here.

Parameters:
- CH, 4, number of independent channels (1..32).
- STAGE, 3, synchronizer flop depth (2..4).
- RST_VAL, {CH{1'b0}}, CH-bit reset value of the sync chain and O_LEVEL.
- FILT_LEN, 4, cycles O_SYNC must hold a new value before O_LEVEL accepts it (1..255).
- Localparam CNT_W = $clog2(FILT_LEN+1).

Ports:
- I_CLK  in  1  destination clock, all state on its rising edge.
- I_RST  in  1  asynchronous, active-high reset; clears all state immediately.
- I_ASYNC  in  CH  asynchronous inputs, one bit per channel.
- I_FILT_EN  in  1  1: filter active; 0: bypass, equivalent to FILT_LEN=1.
- O_SYNC  out  CH  last stage of each sync chain (raw synchronized level).
- O_LEVEL  out  CH  filtered, stable level.
- O_RISE  out  CH  one-cycle pulse when O_LEVEL goes 0->1.
- O_FALL  out  CH  one-cycle pulse when O_LEVEL goes 1->0.
- O_CHG  out  1  OR-reduction of O_RISE|O_FALL, registered in the same cycle.

Behaviour:
- Reset values: sync flops, O_SYNC and O_LEVEL = RST_VAL; counters = 0; O_RISE, O_FALL, O_CHG = 0.
- Reset is asynchronous at assertion and applies mid-operation, discarding in-flight edges.
- No pulse is generated by reset assertion or release itself.
- Sync chain:
  - Per channel, stage[0] <= I_ASYNC, stage[k] <= stage[k-1].
  - O_SYNC = stage[STAGE-1].
  - A level applied before rising edge 1 appears on O_SYNC after edge STAGE.
- Filter, per channel, with counter cnt:
  - If O_SYNC == O_LEVEL: cnt <= 0.
  - Else if cnt == FILT_LEN-1: O_LEVEL <= O_SYNC, cnt <= 0.
  - Else: cnt <= cnt+1.
  - With I_FILT_EN=0 the compare threshold is 0, so O_LEVEL follows O_SYNC one cycle later.
  - I_FILT_EN is sampled every cycle. Toggling it mid-count applies the new threshold immediately. A count >= threshold updates O_LEVEL on the next edge.
- Latency from I_ASYNC to O_LEVEL:
  - Filter enabled: STAGE+FILT_LEN edges (3+4=7 at defaults).
  - Bypass: STAGE+1 edges.
- Glitch rule:
  - O_SYNC differing from O_LEVEL for >= FILT_LEN consecutive cycles propagates.
  - <= FILT_LEN-1 cycles is rejected: counter cleared, no pulse.
  - An alternating O_SYNC never propagates while FILT_LEN > 1.
- Edge outputs:
  - O_RISE <= next_level & ~O_LEVEL and O_FALL <= ~next_level & O_LEVEL, both registered.
  - Each pulse is high exactly in the first cycle O_LEVEL shows the new value, for exactly one cycle.
  - Channels are independent; several channels may pulse in the same cycle, and O_CHG is high once for that cycle.
- Counter never exceeds FILT_LEN-1; no wrap-around is possible.

Test Plan:
- Reset/idle: I_RST=1 for 5 cycles with I_ASYNC=4'hF, then release -> O_LEVEL=0 until edge 7 after release. O_LEVEL=4'hF and O_RISE=4'hF for exactly that one cycle, O_CHG=1, O_FALL=0.
- Latency: FILT_LEN=4, STAGE=3; set I_ASYNC[0]=1 one ns after an edge -> O_SYNC[0]=1 after 3 edges, O_LEVEL[0]=1 and O_RISE[0]=1 after 7 edges. O_RISE[0]=0 on edge 8.
- Glitch: drive I_ASYNC[1] high for exactly 3 cycles -> O_LEVEL[1] stays 0, no O_RISE/O_CHG. Repeat with 4 cycles -> O_LEVEL[1] rises, then falls 4 cycles after O_SYNC[1] returns low, with an O_FALL[1] pulse.
- Bypass: I_FILT_EN=0 and a 1-cycle input pulse -> O_LEVEL follows with latency STAGE+1. O_RISE and O_FALL fire on consecutive cycles.
- Simultaneous/independent: ch2 rises while ch3 falls in the same cycle -> O_RISE=4'b0100 and O_FALL=4'b1000 in the same cycle, a single O_CHG pulse.
- Mid-op reset and randomized run: assert I_RST while cnt=2 -> all outputs return to reset values asynchronously, and no pulse follows release while I_ASYNC==RST_VAL. Then run 30 random CH-bit values, each held 10 cycles -> O_LEVEL equals each value after 7 edges.
